// File: rtl/counter_run_sched_if.sv
// Bus between the requester logic, the shared 8-bit counter and the run scheduler.
// The scheduler sits on the slave side. The requester/counter side uses master.
interface counter_run_sched_if;
    logic [1:0]  req;
    logic [15:0] start_val;
    logic [15:0] run_len;
    logic        pause;
    logic        abort;
    logic [1:0]  grant;
    logic        cnt_load;
    logic [7:0]  cnt_load_val;
    logic        cnt_en;
    logic        cnt_oe;
    logic [7:0]  exp_count;
    logic [1:0]  done;
    logic        aborted;
    logic        busy;

    modport master (
        output req, start_val, run_len, pause, abort,
        input  grant, cnt_load, cnt_load_val, cnt_en, cnt_oe,
        input  exp_count, done, aborted, busy
    );

    modport slave (
        input  req, start_val, run_len, pause, abort,
        output grant, cnt_load, cnt_load_val, cnt_en, cnt_oe,
        output exp_count, done, aborted, busy
    );
endinterface

// File: rtl/counter_run_sched.sv
// Round-robin scheduler that shares one 8-bit loadable up-counter between two
// requesters. It sequences load / count / output-enable for a programmed run and
// keeps a mirror of the value the counter should hold.
module counter_run_sched #(
    parameter int unsigned OE_CYCLES = 4
) (
    input logic                      clk,
    input logic                      rst,
    counter_run_sched_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        SHOW = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] OE_INIT = 8'(OE_CYCLES);

    state_t      state_q, state_d;
    logic        winner_q, winner_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  start_q, start_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [7:0]  oe_cnt_q, oe_cnt_d;
    logic [7:0]  exp_count_q, exp_count_d;
    logic [1:0]  grant_q, grant_d;
    logic        cnt_load_q, cnt_load_d;
    logic [7:0]  cnt_load_val_q, cnt_load_val_d;
    logic        run_q, run_d;
    logic        cnt_oe_q, cnt_oe_d;
    logic [1:0]  done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        busy_q, busy_d;
    logic        count_step;
    logic        abort_taken;

    // Next-state, job bookkeeping and counter mirror. The mirror follows what the
    // counter itself does in every cycle, so the increment or load of the cycle in
    // which abort is seen still lands before the job is dropped.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        start_d      = start_q;
        len_d        = len_q;
        remaining_d  = remaining_q;
        oe_cnt_d     = oe_cnt_q;
        exp_count_d  = exp_count_q;
        count_step   = run_q & ~bus.pause;
        abort_taken  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    if (bus.req == 2'b11) begin
                        winner_d = ~last_grant_q;
                    end else begin
                        winner_d = bus.req[1];
                    end
                    last_grant_d = winner_d;
                    start_d      = winner_d ? bus.start_val[15:8] : bus.start_val[7:0];
                    len_d        = winner_d ? bus.run_len[15:8]   : bus.run_len[7:0];
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                exp_count_d = start_q;
                remaining_d = len_q;
                oe_cnt_d    = OE_INIT;
                state_d     = (len_q != 8'd0) ? RUN : SHOW;
            end
            RUN: begin
                oe_cnt_d = OE_INIT;
                if (count_step) begin
                    exp_count_d = exp_count_q + 8'd1;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = SHOW;
                    end
                end
            end
            SHOW: begin
                oe_cnt_d = oe_cnt_q - 8'd1;
                if (oe_cnt_q == 8'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (((state_q == LOAD) || (state_q == RUN) || (state_q == SHOW)) && bus.abort) begin
            abort_taken = 1'b1;
            state_d     = IDLE;
        end
    end

    // Moore output decode from the state about to be entered, so every control
    // output is a flop that lines up with the registered state.
    always_comb begin
        grant_d        = 2'b00;
        cnt_load_d     = 1'b0;
        cnt_load_val_d = 8'h00;
        run_d          = 1'b0;
        cnt_oe_d       = 1'b0;
        done_d         = 2'b00;
        aborted_d      = abort_taken;
        busy_d         = (state_d != IDLE);

        if ((state_d == LOAD) || (state_d == RUN) || (state_d == SHOW)) begin
            grant_d = winner_d ? 2'b10 : 2'b01;
        end
        if (state_d == LOAD) begin
            cnt_load_d     = 1'b1;
            cnt_load_val_d = start_d;
        end
        if (state_d == RUN) begin
            run_d = 1'b1;
        end
        if (state_d == SHOW) begin
            cnt_oe_d = 1'b1;
        end
        if (state_d == DONE) begin
            done_d = winner_d ? 2'b10 : 2'b01;
        end
    end

    // State and output registers with synchronous reset; requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            winner_q       <= 1'b0;
            last_grant_q   <= 1'b1;
            start_q        <= 8'h00;
            len_q          <= 8'h00;
            remaining_q    <= 8'h00;
            oe_cnt_q       <= 8'h00;
            exp_count_q    <= 8'h00;
            grant_q        <= 2'b00;
            cnt_load_q     <= 1'b0;
            cnt_load_val_q <= 8'h00;
            run_q          <= 1'b0;
            cnt_oe_q       <= 1'b0;
            done_q         <= 2'b00;
            aborted_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            last_grant_q   <= last_grant_d;
            start_q        <= start_d;
            len_q          <= len_d;
            remaining_q    <= remaining_d;
            oe_cnt_q       <= oe_cnt_d;
            exp_count_q    <= exp_count_d;
            grant_q        <= grant_d;
            cnt_load_q     <= cnt_load_d;
            cnt_load_val_q <= cnt_load_val_d;
            run_q          <= run_d;
            cnt_oe_q       <= cnt_oe_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
            busy_q         <= busy_d;
        end
    end

    // Count-enable is the registered RUN flag gated by pause, so a paused cycle
    // never advances the counter.
    assign bus.cnt_en       = run_q & ~bus.pause;
    assign bus.grant        = grant_q;
    assign bus.cnt_load     = cnt_load_q;
    assign bus.cnt_load_val = cnt_load_val_q;
    assign bus.cnt_oe       = cnt_oe_q;
    assign bus.exp_count    = exp_count_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.busy         = busy_q;

    // Grant is never shared and the three counter controls never overlap.
    a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.grant));
    a_ctrl_exclusive : assert property (@(posedge clk) disable iff (rst)
        $onehot0({bus.cnt_load, bus.cnt_en, bus.cnt_oe}));

endmodule

// File: tb/tb_counter_run_sched.sv
// Bench for counter_run_sched: directed jobs followed by randomized jobs, each
// checked cycle by cycle against an expected trace built from the job rules.
module tb_counter_run_sched;

    localparam int OE = 4;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] sv;
        logic [15:0] rl;
        logic        pause;
        logic        abort;
        logic        rst;
        logic [1:0]  grant;
        logic        load;
        logic [7:0]  lval;
        logic        en;
        logic        oe;
        logic [7:0]  expc;
        logic [1:0]  done;
        logic        ab;
        logic        busy;
    } cyc_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    int         lastGrant;
    logic [7:0] expModel;
    logic       abortedPending;

    counter_run_sched_if bus ();

    counter_run_sched #(.OE_CYCLES(OE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, expv);
        end
    endtask

    function automatic logic [1:0] oneHot(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic pickPause(input int mode, input int r);
        if (mode == 0) return 1'b0;
        if (mode == 2) return (r >= 2 && r <= 4);
        return ($urandom_range(0, 9) < 3);
    endfunction

    // Idle cycle: noise on inputs that must not matter, all controls low.
    function automatic cyc_t idleCycle();
        cyc_t c;
        c.req   = 2'b00;
        c.sv    = 16'($urandom);
        c.rl    = 16'($urandom);
        c.pause = 1'($urandom);
        c.abort = ($urandom_range(0, 7) == 0);
        c.rst   = 1'b0;
        c.grant = 2'b00;
        c.load  = 1'b0;
        c.lval  = 8'h00;
        c.en    = 1'b0;
        c.oe    = 1'b0;
        c.expc  = expModel;
        c.done  = 2'b00;
        c.ab    = abortedPending;
        c.busy  = 1'b0;
        return c;
    endfunction

    // Cycle of a job in progress: random req/values that must be ignored.
    function automatic cyc_t busyCycle(input int w);
        cyc_t c;
        c       = idleCycle();
        c.req   = 2'($urandom);
        c.abort = 1'b0;
        c.ab    = 1'b0;
        c.grant = oneHot(w);
        c.busy  = 1'b1;
        return c;
    endfunction

    task automatic stepCycle(input cyc_t c);
        @(posedge clk);
        #1;
        bus.req       = c.req;
        bus.start_val = c.sv;
        bus.run_len   = c.rl;
        bus.pause     = c.pause;
        bus.abort     = c.abort;
        rst           = c.rst;
        #1;
        checkOutput("grant",        32'(bus.grant),        32'(c.grant));
        checkOutput("cnt_load",     32'(bus.cnt_load),     32'(c.load));
        checkOutput("cnt_load_val", 32'(bus.cnt_load_val), 32'(c.lval));
        checkOutput("cnt_en",       32'(bus.cnt_en),       32'(c.en));
        checkOutput("cnt_oe",       32'(bus.cnt_oe),       32'(c.oe));
        checkOutput("exp_count",    32'(bus.exp_count),    32'(c.expc));
        checkOutput("done",         32'(bus.done),         32'(c.done));
        checkOutput("aborted",      32'(bus.aborted),      32'(c.ab));
        checkOutput("busy",         32'(bus.busy),         32'(c.busy));
    endtask

    task automatic finishCycle(input cyc_t c, input logic [7:0] nextExp, output bit stop);
        stop = 1'b0;
        if (c.rst) begin
            lastGrant      = 1;
            expModel       = 8'h00;
            abortedPending = 1'b0;
            stop           = 1'b1;
        end else begin
            expModel = nextExp;
            if (c.abort) begin
                abortedPending = 1'b1;
                stop           = 1'b1;
            end
        end
    endtask

    // One job: optional empty idle cycles, the request cycle, then LOAD, the run
    // with its pause pattern, the output-enable window and the done pulse. An
    // abort or reset at job cycle index k (0 = LOAD) cuts the job short.
    task automatic applyStimulus(input logic [1:0] reqv, input logic [7:0] sv, input logic [7:0] rl,
                                 input int pauseMode, input int abortIdx, input int rstIdx, input int gap);
        cyc_t c;
        int   w;
        int   k;
        int   r;
        int   n;
        bit   stop;

        for (int g = 0; g < gap; g++) begin
            c = idleCycle();
            abortedPending = 1'b0;
            stepCycle(c);
        end

        c     = idleCycle();
        c.req = reqv;
        if (reqv == 2'b11) w = 1 - lastGrant;
        else               w = reqv[1] ? 1 : 0;
        lastGrant = w;
        if (w == 1) begin
            c.sv = {sv, 8'($urandom)};
            c.rl = {rl, 8'($urandom)};
        end else begin
            c.sv = {8'($urandom), sv};
            c.rl = {8'($urandom), rl};
        end
        abortedPending = 1'b0;
        stepCycle(c);

        k      = 0;
        c      = busyCycle(w);
        c.load = 1'b1;
        c.lval = sv;
        c.abort = (abortIdx == k);
        c.rst   = (rstIdx == k);
        stepCycle(c);
        finishCycle(c, sv, stop);
        k++;

        n = 0;
        r = 0;
        while (!stop && n < int'(rl)) begin
            c       = busyCycle(w);
            c.pause = pickPause(pauseMode, r);
            c.en    = ~c.pause;
            c.abort = (abortIdx == k);
            c.rst   = (rstIdx == k);
            stepCycle(c);
            finishCycle(c, c.pause ? expModel : expModel + 8'd1, stop);
            if (!c.pause) n++;
            r++;
            k++;
        end

        for (int i = 0; i < OE && !stop; i++) begin
            c       = busyCycle(w);
            c.oe    = 1'b1;
            c.abort = (abortIdx == k);
            c.rst   = (rstIdx == k);
            stepCycle(c);
            finishCycle(c, expModel, stop);
            k++;
        end

        if (!stop) begin
            c       = busyCycle(w);
            c.grant = 2'b00;
            c.done  = oneHot(w);
            c.abort = ($urandom_range(0, 3) == 0);
            stepCycle(c);
        end
    endtask

    // Directed scenarios first, then randomized jobs.
    initial begin
        cyc_t tail;
        int   lenPick;
        int   abortAt;

        vectors        = 0;
        miscompares    = 0;
        lastGrant      = 1;
        expModel       = 8'h00;
        abortedPending = 1'b0;

        rst           = 1'b1;
        bus.req       = 2'b00;
        bus.start_val = 16'h0000;
        bus.run_len   = 16'h0000;
        bus.pause     = 1'b0;
        bus.abort     = 1'b0;
        repeat (2) @(posedge clk);

        // Both requesting from reset: grants 01, 10, 01.
        applyStimulus(2'b11, 8'h20, 8'd2, 0, -1, -1, 0);
        applyStimulus(2'b11, 8'h40, 8'd2, 0, -1, -1, 0);
        applyStimulus(2'b11, 8'h60, 8'd2, 0, -1, -1, 0);
        // Single job, then wrap through FF.
        applyStimulus(2'b01, 8'h10, 8'd5, 0, -1, -1, 1);
        applyStimulus(2'b01, 8'hFE, 8'd4, 0, -1, -1, 0);
        // Pause for three cycles in the middle of a six-step run.
        applyStimulus(2'b10, 8'h80, 8'd6, 2, -1, -1, 0);
        // Zero-length run goes straight to the output window.
        applyStimulus(2'b01, 8'h55, 8'd0, 0, -1, -1, 0);
        // Abort in the second RUN cycle, then the other requester wins the tie.
        applyStimulus(2'b01, 8'hA0, 8'd5, 0, 2, -1, 0);
        applyStimulus(2'b11, 8'hB0, 8'd1, 0, -1, -1, 0);
        // Reset in the second SHOW cycle, then requester 0 wins the tie.
        applyStimulus(2'b10, 8'h33, 8'd2, 0, -1, 4, 0);
        applyStimulus(2'b11, 8'h44, 8'd3, 0, -1, -1, 0);

        for (int j = 0; j < 60; j++) begin
            lenPick = ($urandom_range(0, 14) == 0) ? 255 : $urandom_range(0, 7);
            abortAt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lenPick + OE) : -1;
            applyStimulus(2'($urandom_range(1, 3)), 8'($urandom), 8'(lenPick), 1,
                          abortAt, -1, $urandom_range(0, 2));
        end

        tail = idleCycle();
        abortedPending = 1'b0;
        stepCycle(tail);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
